// File: rtl/toa_fine_encoder_pipe_if.sv
// rtl/toa_fine_encoder_pipe_if.sv - sample/result bundle for the fine TOA encoder
interface toa_fine_encoder_pipe_if #(
  parameter int N_TAPS = 63,
  parameter int POS_W  = 6,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [N_TAPS-1:0] code_in;
  logic [1:0]        level;
  logic              clr_cnt;
  logic              out_valid;
  logic [POS_W-1:0]  pos;
  logic              no_edge;
  logic              multi_edge;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output in_valid, code_in, level, clr_cnt,
    input  out_valid, pos, no_edge, multi_edge, err_cnt
  );

  modport slave (
    input  in_valid, code_in, level, clr_cnt,
    output out_valid, pos, no_edge, multi_edge, err_cnt
  );
endinterface

// File: rtl/toa_fine_encoder_pipe.sv
// rtl/toa_fine_encoder_pipe.sv - 3-stage bubble-filtered thermometer edge encoder
module toa_fine_encoder_pipe #(
  parameter int N_TAPS = 63,
  parameter int POS_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  toa_fine_encoder_pipe_if.slave    bus
);

  logic              s1_valid;
  logic [N_TAPS-1:0] s1_code;
  logic [1:0]        s1_level;
  logic              s2_valid;
  logic [N_TAPS-1:0] s2_code;
  logic [N_TAPS-1:0] filt;
  logic [2:0]        sum3;
  logic [2:0]        sum5;
  logic [POS_W-1:0]  enc_pos;
  logic              enc_hit;
  logic              enc_multi;

  // Stage 1: capture code with its own filter depth so level changes never leak across samples
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
    end
    if (bus.in_valid) begin
      s1_code  <= bus.code_in;
      s1_level <= bus.level;
    end
  end

  // Circular majority bubble filter; the delay line is treated as a ring
  always_comb begin
    filt = s1_code;
    sum3 = '0;
    sum5 = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      sum3 = 3'(s1_code[(i + N_TAPS - 1) % N_TAPS]) + 3'(s1_code[i])
           + 3'(s1_code[(i + 1) % N_TAPS]);
      sum5 = sum3 + 3'(s1_code[(i + N_TAPS - 2) % N_TAPS])
           + 3'(s1_code[(i + 2) % N_TAPS]);
      case (s1_level)
        2'd2:    filt[i] = (sum3 >= 3'd2);
        2'd3:    filt[i] = (sum5 >= 3'd3);
        default: filt[i] = s1_code[i];
      endcase
    end
  end

  // Stage 2: register the filtered code
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
    if (s1_valid) begin
      s2_code <= filt;
    end
  end

  // 1->0 edge detect with lowest-index priority; no edge reports N_TAPS
  always_comb begin
    enc_pos   = POS_W'(N_TAPS);
    enc_hit   = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (s2_code[i] && !s2_code[(i + 1) % N_TAPS]) begin
        if (enc_hit) begin
          enc_multi = 1'b1;
        end else begin
          enc_hit = 1'b1;
          enc_pos = POS_W'(i);
        end
      end
    end
  end

  // Stage 3: result registers hold their value between valid results
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.pos        <= '0;
      bus.no_edge    <= 1'b0;
      bus.multi_edge <= 1'b0;
    end else begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.pos        <= enc_pos;
        bus.no_edge    <= !enc_hit;
        bus.multi_edge <= enc_multi;
      end
    end
  end

  // Saturating multi-edge counter; clear has priority over a coincident increment
  always_ff @(posedge clk) begin
    if (reset || bus.clr_cnt) begin
      bus.err_cnt <= '0;
    end else if (bus.out_valid && bus.multi_edge && (bus.err_cnt != '1)) begin
      bus.err_cnt <= bus.err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_toa_fine_encoder_pipe.sv
// tb/tb_toa_fine_encoder_pipe.sv - directed vector bench for toa_fine_encoder_pipe
module tb_toa_fine_encoder_pipe;

  typedef struct {
    logic [62:0] code;
    logic [1:0]  level;
    int          exp_pos;
    bit          exp_ne;
    bit          exp_me;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_err  = 0;

  vec_t vecs[12];
  vec_t sq[$];

  toa_fine_encoder_pipe_if #(.N_TAPS(63), .POS_W(6), .CNT_W(16)) bus ();

  toa_fine_encoder_pipe #(.N_TAPS(63), .POS_W(6), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [62:0] lo_bits(input int n);
    logic [62:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [62:0] rot_code(input int k);
    logic [62:0] v = '0;
    for (int i = 0; i < 32; i++) v[(i + k) % 63] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic [62:0] c, input logic [1:0] l, input int p,
                              input bit ne, input bit me);
    vec_t v;
    v.code = c; v.level = l; v.exp_pos = p; v.exp_ne = ne; v.exp_me = me;
    return v;
  endfunction

  function automatic logic [62:0] bit_at(input int i);
    logic [62:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".pos"}, 64'(bus.pos), 64'(v.exp_pos));
    chk({tag, ".no_edge"}, 64'(bus.no_edge), 64'(v.exp_ne));
    chk({tag, ".multi_edge"}, 64'(bus.multi_edge), 64'(v.exp_me));
  endtask

  // Back-to-back stream of sq[], each result checked exactly three cycles after its accept
  task automatic run_stream(input string tag);
    int len = sq.size();
    for (int c = 0; c < len + 2; c++) begin
      if (c < len) begin
        bus.in_valid = 1'b1;
        bus.code_in  = sq[c].code;
        bus.level    = sq[c].level;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (c >= 2) begin
        check_out($sformatf("%s[%0d]", tag, c - 2), sq[c - 2]);
        if (sq[c - 2].exp_me) exp_err++;
      end
    end
    tick();
    chk({tag, ".gap_after"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'(exp_err));
  endtask

  initial begin
    logic [62:0] glitch8;
    glitch8 = lo_bits(16) & ~bit_at(8);

    vecs[0]  = mk(lo_bits(16), 2'd1, 15, 0, 0);
    vecs[1]  = mk('0, 2'd1, 63, 1, 0);
    vecs[2]  = mk('1, 2'd1, 63, 1, 0);
    vecs[3]  = mk(glitch8, 2'd1, 7, 0, 1);
    vecs[4]  = mk(glitch8, 2'd2, 15, 0, 0);
    vecs[5]  = mk(glitch8 & ~bit_at(9), 2'd3, 15, 0, 0);
    vecs[6]  = mk(bit_at(62), 2'd1, 62, 0, 0);
    vecs[7]  = mk(bit_at(62) | bit_at(0), 2'd1, 0, 0, 0);
    vecs[8]  = mk(glitch8, 2'd0, 7, 0, 1);
    vecs[9]  = mk(bit_at(30), 2'd2, 63, 1, 0);
    vecs[10] = mk(lo_bits(16) | bit_at(40), 2'd3, 15, 0, 0);
    vecs[11] = mk(lo_bits(16) | bit_at(40), 2'd1, 15, 0, 1);

    bus.in_valid = 1'b0;
    bus.code_in  = '0;
    bus.level    = 2'd0;
    bus.clr_cnt  = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.pos", 64'(bus.pos), 64'd0);
    chk("rst.no_edge", 64'(bus.no_edge), 64'd0);
    chk("rst.multi_edge", 64'(bus.multi_edge), 64'd0);
    chk("rst.err_cnt", 64'(bus.err_cnt), 64'd0);

    // Isolated samples: exact latency, result and counter per vector
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = 1'b1;
      bus.code_in  = vecs[k].code;
      bus.level    = vecs[k].level;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d.early", k), 64'(bus.out_valid), 64'd0);
      tick();
      check_out($sformatf("vec%0d", k), vecs[k]);
      if (vecs[k].exp_me) exp_err++;
      tick();
      chk($sformatf("vec%0d.hold_valid", k), 64'(bus.out_valid), 64'd0);
      chk($sformatf("vec%0d.hold_pos", k), 64'(bus.pos), 64'(vecs[k].exp_pos));
      chk($sformatf("vec%0d.err_cnt", k), 64'(bus.err_cnt), 64'(exp_err));
    end

    // Consecutive all-0/all-1, then level changing between identical codes
    sq.delete();
    sq.push_back(vecs[1]);
    sq.push_back(vecs[2]);
    sq.push_back(vecs[3]);
    sq.push_back(vecs[4]);
    sq.push_back(vecs[8]);
    run_stream("b2b");

    // 63 rotations back to back: edge walks 31..62 then wraps to 0
    sq.delete();
    for (int k = 0; k < 63; k++) sq.push_back(mk(rot_code(k), 2'd1, (31 + k) % 63, 0, 0));
    run_stream("rot");

    // Reset with three samples in flight
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.code_in  = lo_bits(16);
      bus.level    = 2'd1;
      if (k == 2) reset = 1'b1;
      tick();
    end
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst.err_cnt", 64'(bus.err_cnt), 64'd0);
    exp_err = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst.out_valid%0d", k), 64'(bus.out_valid), 64'd0);
      tick();
    end

    // First sample after reset keeps normal latency
    sq.delete();
    sq.push_back(vecs[6]);
    run_stream("postrst");

    // Saturation: 65540 multi-edge results must stop at 0xFFFF
    bus.in_valid = 1'b1;
    bus.code_in  = glitch8;
    bus.level    = 2'd1;
    for (int k = 0; k < 65540; k++) tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("sat.err_cnt", 64'(bus.err_cnt), 64'hFFFF);

    // Clear coinciding with a multi-edge result wins
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("clr.multi_edge", 64'(bus.multi_edge), 64'd1);
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    chk("clr.err_cnt", 64'(bus.err_cnt), 64'd0);
    tick();
    chk("clr.err_cnt_stays", 64'(bus.err_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/toa_fine_encoder_pipe.md
TOA_FINE_ENCODER_PIPE -- requirements
Module: toa_fine_encoder_pipe

Interface
REQ-001 Parameter N_TAPS, default 63, delay-line tap count; legal range 7..127.
REQ-002 Parameter POS_W, default 6, position width; SHALL satisfy 2**POS_W > N_TAPS.
REQ-003 Parameter CNT_W, default 16, error-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  code_in and level are valid this cycle.
REQ-007 code_in  input  N_TAPS  sampled delay-line code; bit i = tap i.
REQ-008 level  input  2  bubble-filter depth: 0 or 1 = none, 2 = 3-tap majority, 3 = 5-tap majority.
REQ-009 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-010 out_valid  output  1  pos, no_edge and multi_edge are valid.
REQ-011 pos  output  POS_W  encoded edge position.
REQ-012 no_edge  output  1  no 1->0 edge found.
REQ-013 multi_edge  output  1  more than one edge found.
REQ-014 err_cnt  output  CNT_W  saturating count of multi_edge results.

Function
REQ-015 Three-stage pipeline, no backpressure: a sample accepted in cycle T SHALL appear with out_valid=1 in cycle T+3; one sample per cycle sustained.
REQ-016 Stage 1 SHALL register code_in and level together when in_valid=1; the valid bit propagates each cycle regardless of in_valid.
REQ-017 Changing level between samples SHALL affect only samples accepted with that level (level travels with its data).
REQ-018 Stage 2 SHALL compute the filtered code. For level<=1, f[i]=c[i]. For level=2, f[i] = majority of c[i-1], c[i], c[i+1]. For level=3, f[i] = majority of c[i-2..i+2]. All indices are taken mod N_TAPS (circular).
REQ-019 Stage 3 SHALL compute e[i] = f[i] & ~f[(i+1) mod N_TAPS] for all i.
REQ-020 Exactly one e[i] set: pos=i, no_edge=0, multi_edge=0.
REQ-021 No e[i] set (all-0 or all-1 code): pos=N_TAPS, no_edge=1, multi_edge=0.
REQ-022 Two or more e[i] set: pos = lowest such i, multi_edge=1, no_edge=0.
REQ-023 When out_valid=0, pos, no_edge and multi_edge SHALL hold their last values.
REQ-024 err_cnt SHALL increment by 1 in the cycle after out_valid=1 with multi_edge=1, and SHALL saturate at 2**CNT_W-1.
REQ-025 If clr_cnt and an increment occur in the same cycle, clr_cnt SHALL win (err_cnt=0).

Reset
REQ-026 While reset=1 at a clock edge, all pipeline valid bits, out_valid, pos, no_edge, multi_edge and err_cnt SHALL be 0 on the following cycle.
REQ-027 Reset mid-stream SHALL discard all in-flight samples; no out_valid SHALL be produced for samples accepted before or during reset.
REQ-028 The first sample accepted after reset deasserts SHALL emerge with the normal 3-cycle latency.

Verification (N_TAPS=63)
REQ-029 Reset held 2 cycles, then released -> out_valid=0, pos=0, no_edge=0, multi_edge=0, err_cnt=0.
REQ-030 code_in bits 0..15 = 1, rest 0, level=1, in_valid pulse at cycle T -> cycle T+3: out_valid=1, pos=15, no_edge=0, multi_edge=0.
REQ-031 code_in all-0, then all-1, on consecutive cycles -> two consecutive outputs, each pos=63 with no_edge=1.
REQ-032 Bits 0..15 = 1 with bit 8 cleared. level=1 -> pos=7, multi_edge=1, err_cnt becomes 1. Same code with level=2 -> pos=15, multi_edge=0. Same code with bits 8 and 9 cleared and level=3 -> pos=15.
REQ-033 63 back-to-back samples, each a rotation left by 1 of bits 0..31 = 1 -> pos increments 31, 32, ... wrapping 62 -> 0, every cycle with no gaps.
REQ-034 reset asserted 1 cycle while 3 samples are in flight -> no out_valid for those samples. Separately, force err_cnt to 0xFFFF with further multi_edge results -> it stays at 0xFFFF; then clr_cnt together with a multi_edge result -> err_cnt=0.
